raster_restore_buffer: RTL and testbench

Frame buffer that returns the column-major pixel stream from the vertical FIR pass to raster (row-major) order for final image write-out. It sits at the tail of the separable filter chain, after the vertical pass. It is the inverse of the raster-to-column transpose feeding that pass. A full frame is captured at transposed addresses, then drained sequentially with valid/ready back-pressure.

---
 rtl/img_pkg.sv | 20 ++
 rtl/raster_restore_buffer_if.sv | 9 +
 rtl/raster_restore_buffer_sdp_bram.sv | 21 ++
 rtl/raster_restore_buffer.sv | 130 +++++++++++++
 tb/tb_raster_restore_buffer.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/img_pkg.sv
// Shared image-geometry constants and types for the separable filter chain tail.
package img_pkg;
    localparam int unsigned DATA_WIDTH   = 8;
    localparam int unsigned IMAGE_WIDTH  = 110;
    localparam int unsigned IMAGE_HEIGHT = 103;
    localparam int unsigned MEM_SIZE     = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam int unsigned ADDR_W       = $clog2(MEM_SIZE);

    typedef logic [DATA_WIDTH-1:0] pixel_t;

    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    // Address width that stays legal for a single-entry frame.
    function automatic int unsigned addr_width(input int unsigned depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction
endpackage

// File: rtl/raster_restore_buffer_if.sv
// Valid/ready pixel stream; master drives valid and data, slave drives ready.
interface raster_restore_buffer_if;
    logic            valid;
    logic            ready;
    img_pkg::pixel_t data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/raster_restore_buffer_sdp_bram.sv
// Simple dual-port RAM: one write port, one enabled registered read port (1-cycle latency).
module sdp_bram #(
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    (* ram_style = "block" *) logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/raster_restore_buffer.sv
// Captures a column-major frame at transposed addresses, then drains it in raster order
// through a RAM-output plus output-register pipeline with valid/ready back-pressure.
module raster_restore_buffer #(
    parameter int unsigned IMAGE_WIDTH  = img_pkg::IMAGE_WIDTH,
    parameter int unsigned IMAGE_HEIGHT = img_pkg::IMAGE_HEIGHT
) (
    input  logic                     clk,
    input  logic                     reset,
    raster_restore_buffer_if.slave   src,
    raster_restore_buffer_if.master  dst,
    output logic                     frame_done,
    output logic                     busy
);
    import img_pkg::*;

    localparam int unsigned FRAME_PIXELS = IMAGE_WIDTH * IMAGE_HEIGHT;
    localparam int unsigned AW           = addr_width(FRAME_PIXELS);
    localparam logic [7:0]    ROW_LAST   = 8'(IMAGE_HEIGHT - 1);
    localparam logic [7:0]    COL_LAST   = 8'(IMAGE_WIDTH - 1);
    localparam logic [AW-1:0] ROW_STEP   = AW'(IMAGE_WIDTH);
    localparam logic [AW-1:0] RD_LAST    = AW'(FRAME_PIXELS - 1);

    state_t        state, state_nx;
    logic [7:0]    row, col;
    logic [AW-1:0] wr_addr, rd_addr;
    logic          rd_all, ram_vld;
    logic          out_valid;
    pixel_t        out_data, ram_q;
    logic          wr_en, rd_en, out_load, out_fire;

    assign dst.valid = out_valid;
    assign dst.data  = out_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= FILL;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx   = state;
        src.ready  = 1'b0;
        busy       = 1'b0;
        wr_en      = 1'b0;
        rd_en      = 1'b0;
        out_load   = 1'b0;
        out_fire   = 1'b0;
        frame_done = 1'b0;
        case (state)
            FILL: begin
                src.ready = 1'b1;
                wr_en     = src.valid;
                if (src.valid && row == ROW_LAST && col == COL_LAST) state_nx = DRAIN;
            end
            DRAIN: begin
                busy     = 1'b1;
                out_fire = out_valid && dst.ready;
                // RAM output register doubles as the skid entry; it only refills once it empties.
                out_load = ram_vld && (!out_valid || dst.ready);
                rd_en    = !rd_all && (!ram_vld || out_load);
                frame_done = out_fire && rd_all && !ram_vld;
                if (frame_done) state_nx = FILL;
            end
            default: state_nx = FILL;
        endcase
    end

    // Transposed write address kept incrementally: +width down a column, col+1 at column wrap.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            row     <= '0;
            col     <= '0;
            wr_addr <= '0;
        end else if (wr_en) begin
            if (row == ROW_LAST) begin
                row <= '0;
                if (col == COL_LAST) begin
                    col     <= '0;
                    wr_addr <= '0;
                end else begin
                    col     <= col + 8'd1;
                    wr_addr <= AW'(col) + AW'(1);
                end
            end else begin
                row     <= row + 8'd1;
                wr_addr <= wr_addr + ROW_STEP;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_addr   <= '0;
            rd_all    <= 1'b0;
            ram_vld   <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            if (rd_en) begin
                rd_addr <= rd_addr + AW'(1);
                if (rd_addr == RD_LAST) rd_all <= 1'b1;
            end
            if (rd_en)         ram_vld <= 1'b1;
            else if (out_load) ram_vld <= 1'b0;
            if (out_load) begin
                out_valid <= 1'b1;
                out_data  <= ram_q;
            end else if (out_fire) begin
                out_valid <= 1'b0;
            end
            if (frame_done) begin
                rd_addr <= '0;
                rd_all  <= 1'b0;
            end
        end
    end

    sdp_bram #(
        .DW    (DATA_WIDTH),
        .DEPTH (FRAME_PIXELS),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .waddr (wr_addr),
        .wdata (src.data),
        .re    (rd_en),
        .raddr (rd_addr),
        .rdata (ram_q)
    );
endmodule

// File: tb/tb_raster_restore_buffer.sv
// Scoreboarded bench: column-major frames in, raster-order pixels out, with resets and stalls.
module tb_raster_restore_buffer;
    import img_pkg::*;

    localparam int W           = int'(IMAGE_WIDTH);
    localparam int H           = int'(IMAGE_HEIGHT);
    localparam int MEM         = int'(MEM_SIZE);
    localparam int FILL_LIMIT  = 4 * MEM;
    localparam int DRAIN_LIMIT = 8 * MEM + 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic frame_done, busy;
    logic frame_done1, busy1;

    int checks = 0;
    int errors = 0;

    pixel_t model [MEM];
    pixel_t got   [MEM];
    pixel_t exp_q [$];

    raster_restore_buffer_if src ();
    raster_restore_buffer_if dst ();
    raster_restore_buffer_if src1 ();
    raster_restore_buffer_if dst1 ();

    raster_restore_buffer dut (
        .clk        (clk),
        .reset      (reset),
        .src        (src),
        .dst        (dst),
        .frame_done (frame_done),
        .busy       (busy)
    );

    raster_restore_buffer #(
        .IMAGE_WIDTH  (1),
        .IMAGE_HEIGHT (1)
    ) u_one (
        .clk        (clk),
        .reset      (reset),
        .src        (src1),
        .dst        (dst1),
        .frame_done (frame_done1),
        .busy       (busy1)
    );

    always #5 clk = ~clk;

    task automatic test_reset(input string tag);
        #2;
        reset      = 1'b1;
        src.valid  = 1'b0;
        dst.ready  = 1'b0;
        src1.valid = 1'b0;
        dst1.ready = 1'b0;
        #1;
        checks++;
        if (src.ready !== 1'b1 || dst.valid !== 1'b0 || dst.data !== '0 ||
            frame_done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_%s: in_ready=%b out_valid=%b out_data=%h frame_done=%b busy=%b want 1 0 00 0 0",
                     tag, src.ready, dst.valid, dst.data, frame_done, busy);
        end
        @(negedge clk);
        reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic fill_frame(input int valid_pct, input int offset, input int beats);
        int k = 0;
        for (int cyc = 0; cyc < FILL_LIMIT && k < beats; cyc++) begin
            @(negedge clk);
            src.valid = ($urandom_range(0, 99) < valid_pct);
            src.data  = src.valid ? pixel_t'(k + offset) : pixel_t'($urandom);
            #1;
            if (src.valid && src.ready === 1'b1) begin
                model[(k % H) * W + (k / H)] = src.data;
                k++;
            end
        end
        checks++;
        if (k != beats) begin
            errors++;
            $display("FAIL fill_accept: accepted %0d beats, want %0d", k, beats);
        end
        if (beats == MEM)
            for (int i = 0; i < MEM; i++) exp_q.push_back(model[i]);
    endtask

    task automatic drain_frame(input int rdy_pct, input bit poke, input int stop_after,
                               output int n_out, output int first_idx, output int done_idx);
        bit     prev_stall = 1'b0;
        pixel_t prev_data  = '0;
        bit     finished   = 1'b0;
        bit     fire, fd_exp;
        pixel_t want;
        n_out = 0; first_idx = -1; done_idx = -1;
        for (int idx = 0; idx < DRAIN_LIMIT && !finished; idx++) begin
            @(negedge clk);
            dst.ready = ($urandom_range(0, 99) < rdy_pct);
            src.valid = poke;
            src.data  = pixel_t'($urandom);
            #1;
            checks++;
            if (src.ready !== 1'b0 || busy !== 1'b1) begin
                errors++;
                $display("FAIL drain_state: in_ready=%b busy=%b want 0 1 at cycle %0d", src.ready, busy, idx);
            end
            if (prev_stall) begin
                checks++;
                if (dst.valid !== 1'b1 || dst.data !== prev_data) begin
                    errors++;
                    $display("FAIL stall_hold: out_valid=%b out_data=%h want 1 %h", dst.valid, dst.data, prev_data);
                end
            end
            if (first_idx < 0 && dst.valid === 1'b1) first_idx = idx;
            fire = (dst.valid === 1'b1) && dst.ready;
            if (fire) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL extra_output: got %h with empty scoreboard", dst.data);
                end else begin
                    want = exp_q.pop_front();
                    if (dst.data !== want) begin
                        errors++;
                        $display("FAIL pixel[%0d]: got %h want %h", n_out, dst.data, want);
                    end
                end
                if (n_out < MEM) got[n_out] = dst.data;
                n_out++;
            end
            fd_exp = fire && (n_out == MEM);
            checks++;
            if (frame_done !== fd_exp) begin
                errors++;
                $display("FAIL frame_done: got %b want %b after %0d outputs", frame_done, fd_exp, n_out);
            end
            prev_stall = (dst.valid === 1'b1) && !dst.ready;
            prev_data  = dst.data;
            if (frame_done === 1'b1) begin
                done_idx = idx;
                finished = 1'b1;
            end else if (n_out >= stop_after) begin
                finished = 1'b1;
            end
        end
        if (done_idx >= 0) begin
            @(negedge clk);
            src.valid = 1'b0;
            dst.ready = 1'b0;
            #1;
            checks++;
            if (src.ready !== 1'b1 || dst.valid !== 1'b0 || busy !== 1'b0) begin
                errors++;
                $display("FAIL turnaround: in_ready=%b out_valid=%b busy=%b want 1 0 0", src.ready, dst.valid, busy);
            end
        end else if (n_out < stop_after) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d outputs, want %0d", n_out, stop_after);
        end
    endtask

    task automatic test_reset_mid_fill();
        fill_frame(100, 0, 5000);
        test_reset("mid_fill");
    endtask

    task automatic test_reset_mid_drain();
        int n, f, d;
        fill_frame(100, 131, MEM);
        drain_frame(100, 1'b0, 3000, n, f, d);
        test_reset("mid_drain");
    endtask

    task automatic test_full_frame();
        int n, f, d;
        int rs [5] = '{0, 1, 0, 102, 50};
        int cs [5] = '{0, 0, 1, 109, 73};
        pixel_t want;
        fill_frame(100, 0, MEM);
        drain_frame(100, 1'b0, MEM + 1, n, f, d);
        checks++;
        if (n != MEM || exp_q.size() != 0) begin
            errors++;
            $display("FAIL full_count: got %0d outputs (%0d left), want %0d", n, exp_q.size(), MEM);
        end
        checks++;
        if (f != 2) begin
            errors++;
            $display("FAIL first_latency: out_valid first high at cycle %0d, want 2", f);
        end
        checks++;
        if (d != MEM + 1) begin
            errors++;
            $display("FAIL drain_length: frame_done at cycle %0d, want %0d", d, MEM + 1);
        end
        for (int i = 0; i < 5; i++) begin
            want = pixel_t'((cs[i] * H + rs[i]) % 256);
            checks++;
            if (got[rs[i] * W + cs[i]] !== want) begin
                errors++;
                $display("FAIL raster_formula r%0d c%0d: got %h want %h", rs[i], cs[i], got[rs[i] * W + cs[i]], want);
            end
        end
    endtask

    task automatic test_back_to_back();
        int n, f, d;
        fill_frame(80, 57, MEM);
        drain_frame(60, 1'b1, MEM + 1, n, f, d);
        checks++;
        if (n != MEM || exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_count: got %0d outputs (%0d left), want %0d", n, exp_q.size(), MEM);
        end
    endtask

    task automatic test_single_entry();
        pixel_t q1 [$];
        pixel_t want;
        @(negedge clk);
        src1.valid = 1'b1;
        src1.data  = 8'hA5;
        dst1.ready = 1'b1;
        #1;
        checks++;
        if (src1.ready !== 1'b1) begin
            errors++;
            $display("FAIL one_accept: in_ready=%b want 1", src1.ready);
        end
        q1.push_back(src1.data);
        @(negedge clk);
        src1.valid = 1'b0;
        #1;
        checks++;
        if (busy1 !== 1'b1 || src1.ready !== 1'b0 || dst1.valid !== 1'b0) begin
            errors++;
            $display("FAIL one_drain_entry: busy=%b in_ready=%b out_valid=%b want 1 0 0", busy1, src1.ready, dst1.valid);
        end
        @(negedge clk);
        #1;
        checks++;
        if (dst1.valid !== 1'b0) begin
            errors++;
            $display("FAIL one_latency: out_valid=%b one edge after entry, want 0", dst1.valid);
        end
        @(negedge clk);
        #1;
        want = q1.pop_front();
        checks++;
        if (dst1.valid !== 1'b1 || dst1.data !== want || frame_done1 !== 1'b1) begin
            errors++;
            $display("FAIL one_output: out_valid=%b out_data=%h frame_done=%b want 1 %h 1",
                     dst1.valid, dst1.data, frame_done1, want);
        end
        @(negedge clk);
        dst1.ready = 1'b0;
        #1;
        checks++;
        if (src1.ready !== 1'b1 || dst1.valid !== 1'b0 || busy1 !== 1'b0) begin
            errors++;
            $display("FAIL one_return: in_ready=%b out_valid=%b busy=%b want 1 0 0", src1.ready, dst1.valid, busy1);
        end
    endtask

    initial begin
        src.valid  = 1'b0;
        src.data   = '0;
        dst.ready  = 1'b0;
        src1.valid = 1'b0;
        src1.data  = '0;
        dst1.ready = 1'b0;
        test_reset("power_on");
        test_reset_mid_fill();
        test_reset_mid_drain();
        test_full_frame();
        test_back_to_back();
        test_single_entry();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
